// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared constants and types for the common-data-bus arbiter.
//   - ROB index width, default per-source FIFO depth.
//   - Source encoding placed on cdb_src.
//   - Payload layout as stored by the source FIFOs.
//   - Round-robin pointer increment over the three sources.
package cdb_arbiter_pkg;

   localparam int ROB_SIZE_WIDTH   = 5;
   localparam int CDB_QDEPTH       = 4;
   localparam int CDB_QDEPTH_WIDTH = 2;
   localparam int CDB_NSRC         = 3;

   typedef enum logic [1:0] {
      CDB_SRC_ALU = 2'd0,
      CDB_SRC_MEM = 2'd1,
      CDB_SRC_LSB = 2'd2
   } cdb_src_e;

   // Packed so that {value, rob_id} is the 37-bit ALU/MEM FIFO word and
   // {addr, value, rob_id} is the 69-bit LSB FIFO word.
   typedef struct packed {
      logic [31:0]               addr;
      logic [31:0]               value;
      logic [ROB_SIZE_WIDTH-1:0] rob_id;
   } cdb_payload_t;

   localparam int CDB_BASE_W = ROB_SIZE_WIDTH + 32;
   localparam int CDB_LSB_W  = CDB_BASE_W + 32;

   // Next source in the 0 -> 1 -> 2 -> 0 round-robin ring.
   function automatic logic [1:0] cdb_rr_next(input logic [1:0] p);
      return (p >= 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Bundles the three producer channels and the broadcast bus.
//   master : producers / observers (drive valid+payload, see ready+CDB)
//   slave  : the arbiter (sees valid+payload, drives ready+CDB)
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
();

   logic                      alu_valid;
   logic [ROB_SIZE_WIDTH-1:0] alu_rob_id;
   logic [31:0]               alu_value;
   logic                      alu_ready;

   logic                      mem_valid;
   logic [ROB_SIZE_WIDTH-1:0] mem_rob_id;
   logic [31:0]               mem_value;
   logic                      mem_ready;

   logic                      lsb_valid;
   logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id;
   logic [31:0]               lsb_value;
   logic [31:0]               lsb_addr;
   logic                      lsb_ready;

   logic                      cdb_valid;
   logic [1:0]                cdb_src;
   logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id;
   logic [31:0]               cdb_value;
   logic [31:0]               cdb_addr;

   modport master (
      output alu_valid, alu_rob_id, alu_value,
      output mem_valid, mem_rob_id, mem_value,
      output lsb_valid, lsb_rob_id, lsb_value, lsb_addr,
      input  alu_ready, mem_ready, lsb_ready,
      input  cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_addr
   );

   modport slave (
      input  alu_valid, alu_rob_id, alu_value,
      input  mem_valid, mem_rob_id, mem_value,
      input  lsb_valid, lsb_rob_id, lsb_value, lsb_addr,
      output alu_ready, mem_ready, lsb_ready,
      output cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_addr
   );

endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// cdb_arbiter_src_fifo
//   Small per-source result FIFO.
//   clk_in      : clock
//   rst_in      : synchronous active-high reset
//   clear_i     : discard all entries (flush)
//   push_i      : write push_data_i at the tail
//   push_data_i : payload
//   pop_i       : drop the head entry
//   head_o      : current head payload (valid when count_o != 0)
//   count_o     : number of stored entries, 0..DEPTH
module cdb_arbiter_src_fifo #(
   parameter int WIDTH   = 37,
   parameter int DEPTH   = 4,
   parameter int DEPTH_W = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               clear_i,
   input  logic               push_i,
   input  logic [WIDTH-1:0]   push_data_i,
   input  logic               pop_i,
   output logic [WIDTH-1:0]   head_o,
   output logic [DEPTH_W:0]   count_o
);

   localparam logic [DEPTH_W-1:0] PTR_ONE = DEPTH_W'(1);
   localparam logic [DEPTH_W:0]   CNT_ONE = (DEPTH_W + 1)'(1);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [DEPTH_W-1:0] head_q, head_d;
   logic [DEPTH_W-1:0] tail_q, tail_d;
   logic [DEPTH_W:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) tail_d = tail_q + PTR_ONE;
         if (pop_i)  head_d = head_q + PTR_ONE;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk_in) begin
      if (push_i && !clear_i && !rst_in) mem_q[tail_q] <= push_data_i;
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the ROB writeback / CDB broadcast between ALU, MEM and LSB.
//   Each source has a small FIFO; a round-robin arbiter grants at most one
//   result per cycle onto a registered CDB.
//   clk_in   : clock
//   rst_in   : synchronous active-high reset
//   rdy_in   : global enable, low holds all state
//   flush_in : discard all pending results
//   bus      : producer channels, per-source ready, and CDB outputs
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int QDEPTH       = CDB_QDEPTH,
   parameter int QDEPTH_WIDTH = CDB_QDEPTH_WIDTH
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         flush_in,
   cdb_arbiter_if.slave bus
);

   localparam logic [QDEPTH_WIDTH:0] FULL_CNT = (QDEPTH_WIDTH + 1)'(QDEPTH);

   logic                  en;
   logic [2:0]            in_valid;
   logic [2:0]            ready;
   logic [2:0]            acc;
   logic [2:0]            has_q;
   logic [2:0]            cand;
   logic [2:0]            grant;
   logic [2:0]            push;
   logic [2:0]            pop;
   logic [QDEPTH_WIDTH:0] cnt [CDB_NSRC];

   cdb_payload_t          in_pl   [CDB_NSRC];
   cdb_payload_t          head_pl [CDB_NSRC];
   cdb_payload_t          cand_pl [CDB_NSRC];

   logic [CDB_BASE_W-1:0] alu_head;
   logic [CDB_BASE_W-1:0] mem_head;
   logic [CDB_LSB_W-1:0]  lsb_head;

   logic                  win_found;
   logic [1:0]            win_idx;
   logic [1:0]            idx;

   logic                      cdb_valid_q,  cdb_valid_d;
   cdb_src_e                  cdb_src_q,    cdb_src_d;
   logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
   logic [31:0]               cdb_value_q,  cdb_value_d;
   logic [31:0]               cdb_addr_q,   cdb_addr_d;
   logic [1:0]                rr_q,         rr_d;

   assign en       = rdy_in && !flush_in;
   assign in_valid = {bus.lsb_valid, bus.mem_valid, bus.alu_valid};

   always_comb begin
      in_pl[0]   = '{addr: 32'h0, value: bus.alu_value, rob_id: bus.alu_rob_id};
      in_pl[1]   = '{addr: 32'h0, value: bus.mem_value, rob_id: bus.mem_rob_id};
      in_pl[2]   = '{addr: bus.lsb_addr, value: bus.lsb_value, rob_id: bus.lsb_rob_id};
      head_pl[0] = {32'h0, alu_head};
      head_pl[1] = {32'h0, mem_head};
      head_pl[2] = lsb_head;
   end

   // A non-empty FIFO always presents its head, which keeps each source
   // in order; an empty one may bypass the accepted input straight to the CDB.
   always_comb begin
      for (int s = 0; s < CDB_NSRC; s++) begin
         ready[s]   = en && (cnt[s] < FULL_CNT);
         acc[s]     = in_valid[s] && ready[s];
         has_q[s]   = (cnt[s] != '0);
         cand[s]    = en && (has_q[s] || acc[s]);
         cand_pl[s] = has_q[s] ? head_pl[s] : in_pl[s];
      end
   end

   always_comb begin
      win_found = 1'b0;
      win_idx   = rr_q;
      idx       = rr_q;
      for (int k = 0; k < CDB_NSRC; k++) begin
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
         idx = cdb_rr_next(idx);
      end
   end

   // A bypassed winner is consumed directly and never enters its FIFO.
   always_comb begin
      for (int s = 0; s < CDB_NSRC; s++) begin
         grant[s] = win_found && (win_idx == 2'(s));
         pop[s]   = grant[s] && has_q[s];
         push[s]  = acc[s] && !(grant[s] && !has_q[s]);
      end
   end

   cdb_arbiter_src_fifo #(
      .WIDTH(CDB_BASE_W), .DEPTH(QDEPTH), .DEPTH_W(QDEPTH_WIDTH)
   ) u_alu_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clear_i     (flush_in),
      .push_i      (push[0]),
      .push_data_i ({bus.alu_value, bus.alu_rob_id}),
      .pop_i       (pop[0]),
      .head_o      (alu_head),
      .count_o     (cnt[0])
   );

   cdb_arbiter_src_fifo #(
      .WIDTH(CDB_BASE_W), .DEPTH(QDEPTH), .DEPTH_W(QDEPTH_WIDTH)
   ) u_mem_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clear_i     (flush_in),
      .push_i      (push[1]),
      .push_data_i ({bus.mem_value, bus.mem_rob_id}),
      .pop_i       (pop[1]),
      .head_o      (mem_head),
      .count_o     (cnt[1])
   );

   cdb_arbiter_src_fifo #(
      .WIDTH(CDB_LSB_W), .DEPTH(QDEPTH), .DEPTH_W(QDEPTH_WIDTH)
   ) u_lsb_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clear_i     (flush_in),
      .push_i      (push[2]),
      .push_data_i ({bus.lsb_addr, bus.lsb_value, bus.lsb_rob_id}),
      .pop_i       (pop[2]),
      .head_o      (lsb_head),
      .count_o     (cnt[2])
   );

   // Flush only drops cdb_valid; payload fields and rr pointer hold.
   always_comb begin
      cdb_valid_d  = cdb_valid_q;
      cdb_src_d    = cdb_src_q;
      cdb_rob_id_d = cdb_rob_id_q;
      cdb_value_d  = cdb_value_q;
      cdb_addr_d   = cdb_addr_q;
      rr_d         = rr_q;
      if (flush_in) begin
         cdb_valid_d = 1'b0;
      end else if (rdy_in) begin
         if (win_found) begin
            cdb_valid_d  = 1'b1;
            cdb_src_d    = cdb_src_e'(win_idx);
            cdb_rob_id_d = cand_pl[win_idx].rob_id;
            cdb_value_d  = cand_pl[win_idx].value;
            cdb_addr_d   = (win_idx == CDB_SRC_LSB) ? cand_pl[win_idx].addr : 32'h0;
            rr_d         = cdb_rr_next(win_idx);
         end else begin
            cdb_valid_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cdb_valid_q  <= 1'b0;
         cdb_src_q    <= CDB_SRC_ALU;
         cdb_rob_id_q <= '0;
         cdb_value_q  <= '0;
         cdb_addr_q   <= '0;
         rr_q         <= 2'd0;
      end else begin
         cdb_valid_q  <= cdb_valid_d;
         cdb_src_q    <= cdb_src_d;
         cdb_rob_id_q <= cdb_rob_id_d;
         cdb_value_q  <= cdb_value_d;
         cdb_addr_q   <= cdb_addr_d;
         rr_q         <= rr_d;
      end
   end

   assign bus.alu_ready  = ready[0];
   assign bus.mem_ready  = ready[1];
   assign bus.lsb_ready  = ready[2];
   assign bus.cdb_valid  = cdb_valid_q;
   assign bus.cdb_src    = cdb_src_q;
   assign bus.cdb_rob_id = cdb_rob_id_q;
   assign bus.cdb_value  = cdb_value_q;
   assign bus.cdb_addr   = cdb_addr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        flush_in;
   logic [2:0]  tv;
   logic [4:0]  trob [3];
   logic [31:0] tval [3];
   logic [31:0] taddr;

   int n_tests = 0;
   int n_fail  = 0;

   cdb_arbiter_if bus ();

   assign bus.alu_valid  = tv[0];
   assign bus.alu_rob_id = trob[0];
   assign bus.alu_value  = tval[0];
   assign bus.mem_valid  = tv[1];
   assign bus.mem_rob_id = trob[1];
   assign bus.mem_value  = tval[1];
   assign bus.lsb_valid  = tv[2];
   assign bus.lsb_rob_id = trob[2];
   assign bus.lsb_value  = tval[2];
   assign bus.lsb_addr   = taddr;

   cdb_arbiter dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   logic [2:0]  dut_ready;
   logic [71:0] dut_cdb;
   assign dut_ready = {bus.lsb_ready, bus.mem_ready, bus.alu_ready};
   assign dut_cdb   = {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_id, bus.cdb_value, bus.cdb_addr};

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rob;
      logic [31:0] value;
      logic [31:0] addr;
   } ent_t;

   ent_t        mq [3][$];
   int          m_rr;
   logic        m_valid;
   logic [1:0]  m_src;
   logic [4:0]  m_rob;
   logic [31:0] m_val;
   logic [31:0] m_addr;

   function automatic logic [71:0] exp_cdb();
      return {m_valid, m_src, m_rob, m_val, m_addr};
   endfunction

   function automatic logic [2:0] exp_ready();
      logic [2:0] r;
      for (int s = 0; s < 3; s++)
         r[s] = rdy_in && !flush_in && (mq[s].size() < CDB_QDEPTH);
      return r;
   endfunction

   task automatic model_step();
      ent_t in_e [3];
      ent_t c    [3];
      bit   has  [3];
      bit   fromq[3];
      bit   acc  [3];
      int   w;
      if (rst_in) begin
         for (int s = 0; s < 3; s++) mq[s].delete();
         m_rr = 0; m_valid = 0; m_src = 0; m_rob = 0; m_val = 0; m_addr = 0;
         return;
      end
      if (flush_in) begin
         for (int s = 0; s < 3; s++) mq[s].delete();
         m_valid = 0;
         return;
      end
      if (!rdy_in) return;
      for (int s = 0; s < 3; s++) begin
         in_e[s].rob   = trob[s];
         in_e[s].value = tval[s];
         in_e[s].addr  = (s == 2) ? taddr : 32'h0;
         acc[s]   = tv[s] && (mq[s].size() < CDB_QDEPTH);
         has[s]   = 0;
         fromq[s] = 0;
         if (mq[s].size() > 0) begin
            c[s] = mq[s][0]; has[s] = 1; fromq[s] = 1;
         end else if (acc[s]) begin
            c[s] = in_e[s]; has[s] = 1;
         end
      end
      w = -1;
      for (int k = 0; k < 3; k++)
         if (w < 0 && has[(m_rr + k) % 3]) w = (m_rr + k) % 3;
      for (int s = 0; s < 3; s++) begin
         if (s == w && fromq[s]) void'(mq[s].pop_front());
         if (acc[s] && !(s == w && !fromq[s])) mq[s].push_back(in_e[s]);
      end
      if (w >= 0) begin
         m_valid = 1;
         m_src   = 2'(w);
         m_rob   = c[w].rob;
         m_val   = c[w].value;
         m_addr  = c[w].addr;
         m_rr    = (w + 1) % 3;
      end else begin
         m_valid = 0;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      #1;
      model_step();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic do_reset();
      rst_in = 1; rdy_in = 1; flush_in = 0; tv = 3'b000;
      step();
      rst_in = 0;
   endtask

   task automatic rand_payload();
      for (int s = 0; s < 3; s++) begin
         trob[s] = 5'($urandom);
         tval[s] = $urandom;
      end
      taddr = $urandom;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_in = 1; rdy_in = 1; flush_in = 0; tv = 3'b111;
      rand_payload();
      step();
      step();
      rst_in = 0; tv = 3'b000;
      n_tests++;
      if (dut_cdb !== 72'h0) begin
         n_fail++;
         $display("FAIL reset_cdb: got %h want %h", dut_cdb, 72'h0);
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if (dut_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 111", dut_ready);
         end
         step();
         n_tests++;
         if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid: got %b want 0", bus.cdb_valid);
         end
      end
   endtask

   task automatic test_single();
      tv = 3'b001; trob[0] = 5'd5; tval[0] = 32'h1234;
      step();
      tv = 3'b000;
      n_tests++;
      if (dut_cdb !== {1'b1, 2'd0, 5'd5, 32'h1234, 32'h0}) begin
         n_fail++;
         $display("FAIL single_grant: got %h want %h", dut_cdb, {1'b1, 2'd0, 5'd5, 32'h1234, 32'h0});
      end
      step();
      n_tests++;
      if (bus.cdb_valid !== 1'b0 || dut_cdb !== exp_cdb()) begin
         n_fail++;
         $display("FAIL single_after: got %h want %h", dut_cdb, exp_cdb());
      end
   endtask

   task automatic test_burst();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         rand_payload();
         trob[0] = 5'd1; trob[1] = 5'd2; trob[2] = 5'd3;
         tv = 3'b111;
         step();
         tv = 3'b000;
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'(k) || bus.cdb_rob_id !== 5'(k + 1)
                || dut_cdb !== exp_cdb()) begin
               n_fail++;
               $display("FAIL burst_r%0d_k%0d: got %h want src %0d rob %0d (model %h)",
                        r, k, dut_cdb, k, k + 1, exp_cdb());
            end
            step();
         end
         n_tests++;
         if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_drain: got valid %b want 0", bus.cdb_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         rand_payload();
         tv = 3'b111;
         #1;
         n_tests++;
         if (dut_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL bp_ready_%0d: got %b want %b", k, dut_ready, exp_ready());
         end
         step();
         n_tests++;
         if (bus.cdb_src !== 2'(k % 3) || dut_cdb !== exp_cdb()) begin
            n_fail++;
            $display("FAIL bp_grant_%0d: got %h want src %0d (model %h)", k, dut_cdb, k % 3, exp_cdb());
         end
      end
      tv = 3'b000;
      #1;
      n_tests++;
      if (dut_ready !== 3'b100 || dut_ready !== exp_ready()) begin
         n_fail++;
         $display("FAIL bp_full_ready: got %b want 100", dut_ready);
      end
      for (int k = 0; k < 14; k++) begin
         step();
         n_tests++;
         if (dut_cdb !== exp_cdb()) begin
            n_fail++;
            $display("FAIL bp_drain_%0d: got %h want %h", k, dut_cdb, exp_cdb());
         end
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         rand_payload();
         taddr = 32'h100 + 32'(4 * k);
         tv = 3'b111;
         step();
         n_tests++;
         if (dut_cdb !== exp_cdb()) begin
            n_fail++;
            $display("FAIL flush_fill_%0d: got %h want %h", k, dut_cdb, exp_cdb());
         end
      end
      tv = 3'b000; rdy_in = 0; flush_in = 1;
      #1;
      n_tests++;
      if (dut_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL flush_ready_low: got %b want 000", dut_ready);
      end
      step();
      flush_in = 0; rdy_in = 1;
      #1;
      n_tests++;
      if (bus.cdb_valid !== 1'b0 || dut_ready !== 3'b111 || dut_cdb !== exp_cdb()) begin
         n_fail++;
         $display("FAIL flush_after: got v=%b rdy=%b cdb=%h want v=0 rdy=111 cdb=%h",
                  bus.cdb_valid, dut_ready, dut_cdb, exp_cdb());
      end
      for (int k = 0; k < 5; k++) begin
         step();
         n_tests++;
         if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stale_%0d: got valid %b want 0", k, bus.cdb_valid);
         end
      end
   endtask

   task automatic test_hold();
      logic [31:0] v_alu;
      logic [31:0] v_mem;
      do_reset();
      rand_payload();
      v_alu = tval[0]; v_mem = tval[1];
      trob[0] = 5'd7; trob[1] = 5'd9;
      tv = 3'b011;
      step();
      rdy_in = 0; tv = 3'b111;
      for (int k = 0; k < 4; k++) begin
         rand_payload();
         #1;
         n_tests++;
         if (dut_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_ready_%0d: got %b want 000", k, dut_ready);
         end
         step();
         n_tests++;
         if (dut_cdb !== {1'b1, 2'd0, 5'd7, v_alu, 32'h0} || dut_cdb !== exp_cdb()) begin
            n_fail++;
            $display("FAIL hold_frozen_%0d: got %h want %h", k, dut_cdb, {1'b1, 2'd0, 5'd7, v_alu, 32'h0});
         end
      end
      rdy_in = 1; tv = 3'b000;
      step();
      n_tests++;
      if (dut_cdb !== {1'b1, 2'd1, 5'd9, v_mem, 32'h0}) begin
         n_fail++;
         $display("FAIL hold_resume: got %h want %h", dut_cdb, {1'b1, 2'd1, 5'd9, v_mem, 32'h0});
      end
      step();
      n_tests++;
      if (bus.cdb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_end: got valid %b want 0", bus.cdb_valid);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rand_payload();
         rdy_in   = ($urandom_range(0, 7) != 0);
         flush_in = ($urandom_range(0, 31) == 0);
         tv       = 3'($urandom);
         #1;
         n_tests++;
         if (dut_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL rand_ready_%0d: got %b want %b", k, dut_ready, exp_ready());
         end
         step();
         n_tests++;
         if (dut_cdb !== exp_cdb()) begin
            n_fail++;
            $display("FAIL rand_cdb_%0d: got %h want %h", k, dut_cdb, exp_cdb());
         end
      end
      rdy_in = 1; flush_in = 0; tv = 3'b000;
   endtask

   initial begin
      rst_in = 1; rdy_in = 1; flush_in = 0; tv = 3'b000; taddr = 32'h0;
      for (int s = 0; s < 3; s++) begin
         trob[s] = 5'd0;
         tval[s] = 32'h0;
      end
      m_rr = 0; m_valid = 0; m_src = 0; m_rob = 0; m_val = 0; m_addr = 0;
      @(negedge clk_in);
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_flush();
      test_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
